// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode, register-file, writeback and issue signals of operand_fetch
interface operand_fetch_if #(
   parameter int ADDR  = 5,
   parameter int BUS_W = 32
);
   logic             id_valid;
   logic             id_ready;
   logic [ADDR-1:0]  id_rs;
   logic [ADDR-1:0]  id_rt;
   logic [ADDR-1:0]  id_rd;
   logic [ADDR-1:0]  rs_addr;
   logic [ADDR-1:0]  rt_addr;
   logic [BUS_W-1:0] rs_data;
   logic [BUS_W-1:0] rt_data;
   logic             wb_write;
   logic [ADDR-1:0]  wb_addr;
   logic [BUS_W-1:0] wb_data;
   logic             op_valid;
   logic             op_ready;
   logic [BUS_W-1:0] op_a;
   logic [BUS_W-1:0] op_b;
   logic [ADDR-1:0]  op_rd;

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, rs_data, rt_data,
             wb_write, wb_addr, wb_data, op_ready,
      output id_ready, rs_addr, rt_addr, op_valid, op_a, op_b, op_rd
   );

   modport master (
      output id_valid, id_rs, id_rt, id_rd, rs_data, rt_data,
             wb_write, wb_addr, wb_data, op_ready,
      input  id_ready, rs_addr, rt_addr, op_valid, op_a, op_b, op_rd
   );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read stage with writeback forwarding and pending-write scoreboard
module operand_fetch #(
   parameter int ADDR  = 5,
   parameter int BUS_W = 32
) (
   input  logic              reloj_cucu,
   input  logic              reset,
   operand_fetch_if.slave    bus,
   output logic [15:0]       stall_count
);
   localparam int NREG = 1 << ADDR;

   logic [NREG-1:0]  r_pend;
   logic [NREG-1:0]  w_pend_nxt;
   logic             r_op_valid;
   logic [BUS_W-1:0] r_op_a;
   logic [BUS_W-1:0] r_op_b;
   logic [ADDR-1:0]  r_op_rd;
   logic [15:0]      r_stall;

   logic             w_rs_fwd;
   logic             w_rt_fwd;
   logic             w_rs_haz;
   logic             w_rt_haz;
   logic             w_hazard;
   logic             w_ready;
   logic             w_accept;
   logic [BUS_W-1:0] w_a;
   logic [BUS_W-1:0] w_b;

   assign bus.rs_addr = bus.id_rs;
   assign bus.rt_addr = bus.id_rt;

   // A same-cycle writeback both supplies the value and retires the hazard.
   assign w_rs_fwd = bus.wb_write && (bus.wb_addr == bus.id_rs);
   assign w_rt_fwd = bus.wb_write && (bus.wb_addr == bus.id_rt);

   assign w_a = (bus.id_rs == '0) ? '0 : (w_rs_fwd ? bus.wb_data : bus.rs_data);
   assign w_b = (bus.id_rt == '0) ? '0 : (w_rt_fwd ? bus.wb_data : bus.rt_data);

   assign w_rs_haz = (bus.id_rs != '0) && r_pend[bus.id_rs] && !w_rs_fwd;
   assign w_rt_haz = (bus.id_rt != '0) && r_pend[bus.id_rt] && !w_rt_fwd;
   assign w_hazard = bus.id_valid && (w_rs_haz || w_rt_haz);

   assign w_ready  = (!r_op_valid || bus.op_ready) && !w_hazard;
   assign w_accept = bus.id_valid && w_ready;

   // Set is applied after clear so a younger producer keeps its bit.
   always_comb begin
      w_pend_nxt = r_pend;
      if (bus.wb_write) begin
         w_pend_nxt[bus.wb_addr] = 1'b0;
      end
      if (w_accept && (bus.id_rd != '0)) begin
         w_pend_nxt[bus.id_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge reloj_cucu or negedge reset) begin
      if (!reset) begin
         r_pend     <= '0;
         r_op_valid <= 1'b0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_rd    <= '0;
         r_stall    <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_accept) begin
            r_op_valid <= 1'b1;
            r_op_a     <= w_a;
            r_op_b     <= w_b;
            r_op_rd    <= bus.id_rd;
         end else if (r_op_valid && bus.op_ready) begin
            r_op_valid <= 1'b0;
         end
         if (w_hazard && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
         end
      end
   end

   assign bus.id_ready = w_ready;
   assign bus.op_valid = r_op_valid;
   assign bus.op_a     = r_op_a;
   assign bus.op_b     = r_op_b;
   assign bus.op_rd    = r_op_rd;
   assign stall_count  = r_stall;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed and randomized bench for operand_fetch with a queue-based reference model
module tb_operand_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] stall_count;

   operand_fetch_if bus ();

   operand_fetch dut (
      .reloj_cucu  (clk),
      .reset       (reset),
      .bus         (bus),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } bundle_t;

   logic [31:0] rf [32];
   logic [31:0] pend;
   bundle_t     q[$];
   int          stall;
   int          nchk  = 0;
   int          nfail = 0;
   logic        last_acc;

   assign bus.rs_data = rf[bus.rs_addr];
   assign bus.rt_data = rf[bus.rt_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      nchk++;
      assert (obs === want) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] src_val(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (bus.wb_write && bus.wb_addr == r) return bus.wb_data;
      return rf[r];
   endfunction

   function automatic logic src_haz(input logic [4:0] r);
      return (r != 5'd0) && pend[r] && !(bus.wb_write && bus.wb_addr == r);
   endfunction

   // One clock of stimulus: predict, check handshake, cross the edge, update model, check state.
   task automatic tick();
      logic        haz, want_rdy, acc, pop;
      logic [31:0] va, vb;
      #1;
      haz      = bus.id_valid && (src_haz(bus.id_rs) || src_haz(bus.id_rt));
      want_rdy = (q.size() == 0 || bus.op_ready) && !haz;
      chk("id_ready", {31'd0, bus.id_ready}, {31'd0, want_rdy});
      chk("rs_addr", {27'd0, bus.rs_addr}, {27'd0, bus.id_rs});
      if (q.size() != 0) begin
         chk("op_a", bus.op_a, q[0].a);
         chk("op_b", bus.op_b, q[0].b);
         chk("op_rd", {27'd0, bus.op_rd}, {27'd0, q[0].rd});
      end
      acc = bus.id_valid && want_rdy;
      pop = (q.size() != 0) && bus.op_ready;
      va  = src_val(bus.id_rs);
      vb  = src_val(bus.id_rt);
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{a: va, b: vb, rd: bus.id_rd});
      if (bus.wb_write) begin
         pend[bus.wb_addr] = 1'b0;
         rf[bus.wb_addr]   = bus.wb_data;
      end
      if (acc && bus.id_rd != 5'd0) pend[bus.id_rd] = 1'b1;
      if (haz && stall < 65535) stall++;
      last_acc = acc;
      chk("op_valid", {31'd0, bus.op_valid}, {31'd0, q.size() != 0});
      chk("stall_count", {16'd0, stall_count}, 32'(stall));
      @(negedge clk);
   endtask

   task automatic issue(input int rs, input int rt, input int rd);
      bus.id_valid = 1'b1;
      bus.id_rs    = 5'(rs);
      bus.id_rt    = 5'(rt);
      bus.id_rd    = 5'(rd);
   endtask

   task automatic wb(input logic en, input int addr, input logic [31:0] data);
      bus.wb_write = en;
      bus.wb_addr  = 5'(addr);
      bus.wb_data  = data;
   endtask

   task automatic model_reset();
      q.delete();
      pend  = '0;
      stall = 0;
   endtask

   initial begin
      int          s0;
      bundle_t     held;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
      model_reset();
      last_acc     = 1'b0;
      bus.id_valid = 1'b0;
      bus.id_rs    = '0;
      bus.id_rt    = '0;
      bus.id_rd    = '0;
      bus.op_ready = 1'b1;
      wb(1'b0, 0, 32'd0);
      reset = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
      chk("rst_op_a", bus.op_a, 32'd0);
      chk("rst_op_b", bus.op_b, 32'd0);
      chk("rst_op_rd", {27'd0, bus.op_rd}, 32'd0);
      chk("rst_stall", {16'd0, stall_count}, 32'd0);
      chk("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
      reset = 1'b1;

      // single issue
      rf[5] = 32'h55;
      rf[6] = 32'h66;
      issue(5, 6, 7);
      tick();
      bus.id_valid = 1'b0;
      chk("single_op_a", bus.op_a, 32'h55);
      chk("single_op_b", bus.op_b, 32'h66);
      chk("single_op_rd", {27'd0, bus.op_rd}, 32'd7);
      chk("single_valid", {31'd0, bus.op_valid}, 32'd1);
      tick();
      chk("single_valid_drop", {31'd0, bus.op_valid}, 32'd0);

      // zero register
      rf[0] = 32'hDEAD_BEEF;
      s0 = stall;
      issue(0, 0, 0);
      wb(1'b1, 0, 32'hFFFF);
      tick();
      bus.id_valid = 1'b0;
      wb(1'b0, 0, 32'd0);
      chk("zero_op_a", bus.op_a, 32'd0);
      chk("zero_op_b", bus.op_b, 32'd0);
      chk("zero_nostall", {16'd0, stall_count}, 32'(s0));
      wb(1'b1, 7, 32'h77);
      tick();
      wb(1'b0, 0, 32'd0);

      // RAW hazard resolved by same-cycle writeback
      issue(1, 2, 3);
      tick();
      s0 = stall;
      issue(3, 0, 0);
      tick();
      tick();
      chk("raw_stall_cnt", {16'd0, stall_count}, 32'(s0 + 2));
      wb(1'b1, 3, 32'hABCD);
      tick();
      bus.id_valid = 1'b0;
      wb(1'b0, 0, 32'd0);
      chk("raw_fwd_op_a", bus.op_a, 32'hABCD);

      // set/clear collision keeps the pending bit
      issue(0, 0, 4);
      tick();
      issue(0, 0, 4);
      wb(1'b1, 4, 32'h44);
      tick();
      wb(1'b0, 0, 32'd0);
      s0 = stall;
      issue(4, 0, 0);
      tick();
      chk("collide_stall", {16'd0, stall_count}, 32'(s0 + 1));
      wb(1'b1, 4, 32'h4444);
      tick();
      bus.id_valid = 1'b0;
      wb(1'b0, 0, 32'd0);
      chk("collide_op_a", bus.op_a, 32'h4444);

      // backpressure
      bus.op_ready = 1'b0;
      issue(1, 2, 8);
      tick();
      held = q[0];
      issue(5, 6, 9);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_a", bus.op_a, held.a);
         chk("bp_hold_rd", {27'd0, bus.op_rd}, {27'd0, held.rd});
      end
      bus.op_ready = 1'b1;
      tick();
      bus.id_valid = 1'b0;
      chk("bp_second_a", bus.op_a, 32'h55);
      chk("bp_second_rd", {27'd0, bus.op_rd}, 32'd9);
      tick();

      // asynchronous reset while a bundle is held and a hazard is stalling
      bus.op_ready = 1'b0;
      issue(0, 0, 10);
      tick();
      issue(10, 0, 0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_op_valid", {31'd0, bus.op_valid}, 32'd0);
      chk("arst_stall", {16'd0, stall_count}, 32'd0);
      model_reset();
      bus.id_valid = 1'b0;
      @(negedge clk);
      reset        = 1'b1;
      bus.op_ready = 1'b1;
      issue(10, 0, 0);
      tick();
      bus.id_valid = 1'b0;
      chk("arst_reissue_rd", {27'd0, bus.op_rd}, 32'd0);
      tick();

      // randomized traffic; upstream holds a stalled instruction
      last_acc = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!(bus.id_valid && !last_acc)) begin
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_rs    = 5'($urandom_range(0, 7));
            bus.id_rt    = 5'($urandom_range(0, 7));
            bus.id_rd    = 5'($urandom_range(0, 7));
         end
         wb($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
         bus.op_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.id_valid = 1'b0;
      bus.op_ready = 1'b1;
      wb(1'b0, 0, 32'd0);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
